// File: rtl/cpu_regfile_sb_pkg.sv
// Shared CPU package: default register-file geometry and the matching data/address types.
package cpu_pkg;
    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 4;

    typedef logic [DATA_W_DEF-1:0] data_t;
    typedef logic [ADDR_W_DEF-1:0] reg_addr_t;
endpackage

// File: rtl/cpu_regfile_sb_scoreboard.sv
// Busy scoreboard: one busy bit per register, issue (set) beats write (clear),
// with a registered lookup of the post-edge busy state for two addresses.
module cpu_scoreboard
    import cpu_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int ZERO_R0 = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              set_en,
    input  logic [ADDR_W-1:0] set_addr,
    input  logic              clr_en,
    input  logic [ADDR_W-1:0] clr_addr,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [ADDR_W-1:0] addr_b,
    output logic              hazard_a,
    output logic              hazard_b
);
    localparam int NUM_REGS = 2**ADDR_W;

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;

    // A new producer supersedes a completing one, so the set is applied last.
    always_comb begin
        busy_d = busy_q;
        if (clr_en) busy_d[clr_addr] = 1'b0;
        if (set_en) busy_d[set_addr] = 1'b1;
        if (ZERO_R0 != 0) busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q   <= '0;
            hazard_a <= 1'b0;
            hazard_b <= 1'b0;
        end else begin
            busy_q   <= busy_d;
            hazard_a <= busy_d[addr_a];
            hazard_b <= busy_d[addr_b];
        end
    end
endmodule

// File: rtl/cpu_regfile_sb.sv
// Parametrised register file with busy scoreboard and gated bus output.
// Define CPU_REGFILE_BYPASS_EN to forward same-edge write data to all read outputs.
module cpu_regfile_sb
    import cpu_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int ZERO_R0 = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_in,
    input  logic [ADDR_W-1:0] rs,
    input  logic [ADDR_W-1:0] rt,
    input  logic [ADDR_W-1:0] rd,
    input  logic              enable_write,
    input  logic              output_enable,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_rd,
    output logic [DATA_W-1:0] reg_a,
    output logic [DATA_W-1:0] reg_b,
    output logic              hazard_a,
    output logic              hazard_b,
    output logic [DATA_W-1:0] data_out
);
    localparam int NUM_REGS = 2**ADDR_W;

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic              wr_ok;
    logic              fwd_a, fwd_b, fwd_d;
    logic [DATA_W-1:0] val_a, val_b, val_d;

    assign wr_ok = enable_write && !((ZERO_R0 != 0) && (rd == '0));

`ifdef CPU_REGFILE_BYPASS_EN
    assign fwd_a = enable_write && (rd == rs);
    assign fwd_b = enable_write && (rd == rt);
    assign fwd_d = enable_write;
`else
    assign fwd_a = 1'b0;
    assign fwd_b = 1'b0;
    assign fwd_d = 1'b0;
`endif

    // Register 0 reads as zero even when forwarding would supply data_in.
    always_comb begin
        val_a = fwd_a ? data_in : regs[rs];
        val_b = fwd_b ? data_in : regs[rt];
        val_d = fwd_d ? data_in : regs[rd];
        if ((ZERO_R0 != 0) && (rs == '0)) val_a = '0;
        if ((ZERO_R0 != 0) && (rt == '0)) val_b = '0;
        if ((ZERO_R0 != 0) && (rd == '0)) val_d = '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
            reg_a    <= '0;
            reg_b    <= '0;
            data_out <= '0;
        end else begin
            if (wr_ok) regs[rd] <= data_in;
            reg_a    <= val_a;
            reg_b    <= val_b;
            data_out <= output_enable ? val_d : '0;
        end
    end

    cpu_scoreboard #(
        .ADDR_W  (ADDR_W),
        .ZERO_R0 (ZERO_R0)
    ) u_sb (
        .clk      (clk),
        .rst      (rst),
        .set_en   (issue_valid),
        .set_addr (issue_rd),
        .clr_en   (enable_write),
        .clr_addr (rd),
        .addr_a   (rs),
        .addr_b   (rt),
        .hazard_a (hazard_a),
        .hazard_b (hazard_b)
    );
endmodule

// File: tb/tb_cpu_regfile_sb.sv
// Self-checking bench for cpu_regfile_sb: directed literal checks plus random traffic vs. a behavioural model.
module tb_cpu_regfile_sb;
    localparam int ZR = 1;
`ifdef CPU_REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] data_in = '0;
    logic [3:0] rs = '0, rt = '0, rd = '0, issue_rd = '0;
    logic       enable_write = 1'b0, output_enable = 1'b0, issue_valid = 1'b0;
    logic [7:0] reg_a, reg_b, data_out;
    logic       hazard_a, hazard_b;

    int checks = 0;
    int passes = 0;
    bit cmp_on = 1'b0;

    cpu_regfile_sb #(.DATA_W(8), .ADDR_W(4), .ZERO_R0(ZR)) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .rs(rs), .rt(rt), .rd(rd),
        .enable_write(enable_write), .output_enable(output_enable),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .reg_a(reg_a), .reg_b(reg_b), .hazard_a(hazard_a), .hazard_b(hazard_b),
        .data_out(data_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Behavioural model: architectural register and busy arrays.
    logic [7:0] m_regs [16];
    bit         m_busy [16];
    logic [7:0] e_a = '0, e_b = '0, e_do = '0;
    bit         e_ha = 1'b0, e_hb = 1'b0;

    function automatic bit writable(input logic [3:0] a);
        return !(ZR != 0 && a == 0);
    endfunction

    function automatic logic [7:0] mval(input logic [3:0] a);
        if (!writable(a)) return 8'h00;
        if (BYP && enable_write && rd == a) return data_in;
        return m_regs[a];
    endfunction

    initial for (int i = 0; i < 16; i++) begin m_regs[i] = '0; m_busy[i] = 1'b0; end

    always @(posedge clk or negedge rst) begin
        bit nb [16];
        if (!rst) begin
            for (int i = 0; i < 16; i++) begin m_regs[i] = '0; m_busy[i] = 1'b0; end
            e_a = '0; e_b = '0; e_do = '0; e_ha = 1'b0; e_hb = 1'b0;
        end else begin
            nb = m_busy;
            if (enable_write && writable(rd)) nb[rd] = 1'b0;
            if (issue_valid && writable(issue_rd)) nb[issue_rd] = 1'b1;
            e_a  = mval(rs);
            e_b  = mval(rt);
            e_do = output_enable ? mval(rd) : 8'h00;
            e_ha = nb[rs];
            e_hb = nb[rt];
            if (enable_write && writable(rd)) m_regs[rd] = data_in;
            m_busy = nb;
        end
    end

    always @(negedge clk) begin
        if (cmp_on) begin
            chk("m_reg_a", reg_a, e_a);
            chk("m_reg_b", reg_b, e_b);
            chk("m_haz_a", {7'b0, hazard_a}, {7'b0, e_ha});
            chk("m_haz_b", {7'b0, hazard_b}, {7'b0, e_hb});
            chk("m_dout", data_out, e_do);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        enable_write = 1'b0; issue_valid = 1'b0; output_enable = 1'b0;
    endtask

    initial begin
        #2 rst = 1'b0;
        cmp_on = 1'b1;
        repeat (2) cyc();
        rst = 1'b1;
        chk("rst_reg_a", reg_a, 8'h00);
        chk("rst_reg_b", reg_b, 8'h00);
        chk("rst_haz", {6'b0, hazard_a, hazard_b}, 8'h00);
        chk("rst_dout", data_out, 8'h00);

        // write/read
        enable_write = 1; rd = 4; data_in = 8'd30; cyc();
        idle(); rs = 4; rt = 3; cyc();
        chk("wr_reg_a", reg_a, 8'd30);
        chk("wr_reg_b", reg_b, 8'd0);

        // same-edge write and read
        enable_write = 1; rd = 5; data_in = 8'h5A; rs = 5; cyc();
        chk("byp_reg_a", reg_a, BYP ? 8'h5A : 8'h00);
        idle(); cyc();
        chk("byp_next", reg_a, 8'h5A);

        // zero register
        enable_write = 1; rd = 0; data_in = 8'hFF; issue_valid = 1; issue_rd = 0; cyc();
        idle(); rs = 0; cyc();
        chk("r0_val", reg_a, 8'h00);
        chk("r0_haz", {7'b0, hazard_a}, 8'h00);

        // scoreboard
        issue_valid = 1; issue_rd = 7; cyc();
        idle(); rs = 7; cyc();
        chk("sb_busy", {7'b0, hazard_a}, 8'h01);
        enable_write = 1; rd = 7; data_in = 8'h11; cyc();
        chk("sb_clear", {7'b0, hazard_a}, 8'h00);
        idle(); cyc();
        chk("sb_val", reg_a, 8'h11);

        // issue/write collision
        issue_valid = 1; issue_rd = 2; enable_write = 1; rd = 2; data_in = 8'd9; rt = 2; cyc();
        chk("coll_haz", {7'b0, hazard_b}, 8'h01);
        idle(); cyc();
        chk("coll_val", reg_b, 8'd9);
        chk("coll_haz2", {7'b0, hazard_b}, 8'h01);

        // data_out
        enable_write = 1; rd = 4; data_in = 8'h3C; cyc();
        idle(); output_enable = 1; cyc();
        chk("dout_on", data_out, 8'h3C);
        output_enable = 0; cyc();
        chk("dout_off", data_out, 8'h00);
        output_enable = 1; cyc();
        chk("dout_on2", data_out, 8'h3C);
        #2 rst = 1'b0;
        #1;
        chk("dout_async_rst", data_out, 8'h00);
        chk("rega_async_rst", reg_a, 8'h00);
        chk("hazb_async_rst", {7'b0, hazard_b}, 8'h00);
        cyc();
        rst = 1'b1;
        idle();

        // random traffic with occasional mid-run resets
        for (int n = 0; n < 3000; n++) begin
            rst           = ($urandom_range(0, 99) != 0);
            data_in       = 8'($urandom);
            rs            = 4'($urandom_range(0, 7));
            rt            = 4'($urandom_range(0, 7));
            rd            = 4'($urandom_range(0, 7));
            issue_rd      = 4'($urandom_range(0, 7));
            enable_write  = $urandom_range(0, 1) != 0;
            issue_valid   = $urandom_range(0, 2) == 0;
            output_enable = $urandom_range(0, 1) != 0;
            cyc();
        end
        rst = 1'b1;
        idle();
        cyc();
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/cpu_regfile_sb.md
# cpu_regfile_sb

Parametrised successor to the 8-bit CPU register file. It provides a generic-width, generic-depth register file with:
- two registered read ports and one write port;
- a per-register busy scoreboard, so the issue stage can detect read-after-write hazards on in-flight destinations;
- a registered, output-enabled data port for the bus.

It sits between the decode/issue stage and the ALU/writeback path of the CPU core.

## Interface
Parameters:
- DATA_W, 8, data width in bits
- ADDR_W, 4, register address width; NUM_REGS = 2**ADDR_W
- ZERO_R0, 1, 1 = register 0 is hard-wired to zero and never busy; 0 = register 0 is an ordinary register

Ports:
- clk  in  1  single clock; all state changes on the rising edge
- rst  in  1  asynchronous, active-low reset
- data_in  in  DATA_W  write data
- rs  in  ADDR_W  read address, port A
- rt  in  ADDR_W  read address, port B
- rd  in  ADDR_W  write address; also the data_out read address
- enable_write  in  1  write data_in to reg[rd]; clears busy[rd]
- output_enable  in  1  load data_out from reg[rd]
- issue_valid  in  1  mark issue_rd busy (new producer in flight)
- issue_rd  in  ADDR_W  destination being issued
- reg_a  out  DATA_W  registered read of reg[rs]
- reg_b  out  DATA_W  registered read of reg[rt]
- hazard_a  out  1  registered busy[rs], aligned with reg_a
- hazard_b  out  1  registered busy[rt], aligned with reg_b
- data_out  out  DATA_W  registered bus output

## Operation
- Storage: NUM_REGS × DATA_W flops. Address widths are exact, so no out-of-range case exists.
- Write: when enable_write=1 at an edge, reg[rd] <= data_in and busy[rd] <= 0.
  - With ZERO_R0=1 and rd=0, the write is discarded.
- Issue: when issue_valid=1 at an edge, busy[issue_rd] <= 1.
  - With ZERO_R0=1 and issue_rd=0, the issue is ignored.
- Simultaneous issue and write to the same register: the issue wins. Storage updates and busy ends at 1, because the new producer supersedes the old one.
- Read ports: every edge, reg_a <= value(rs), reg_b <= value(rt), hazard_a <= busy[rs], hazard_b <= busy[rt].
  - value() of register 0 is 0 when ZERO_R0=1.
  - Reads are not gated by any enable.
- Hazard bypass on the busy bit: a write in the same edge to the addressed register clears hazard_x, unless an issue to that register is also present in that edge.
- data_out:
  - When output_enable=1 at an edge, data_out <= value(rd).
  - When output_enable=0, data_out <= 0.
- Reset (rst=0): immediately and asynchronously, all registers, all busy bits, reg_a, reg_b, hazard_a, hazard_b and data_out go to 0.
  - Reset asserted mid-operation drops any in-progress write or issue.
  - The first edge after rst rises behaves normally.

## Timing
- Write latency: 1 edge. The value is visible on a read port one edge later via storage, or in the same edge via bypass (see Configuration).
- Read latency: 1 cycle. Addresses presented before edge N appear on reg_a/reg_b after edge N.
- data_out latency: 1 cycle after output_enable is sampled.
- Busy set and clear take effect at the sampling edge. Hazard outputs reflect the post-edge busy state of the addressed register.
- No handshake. Every input is sampled on every edge.

## Configuration
- CPU_REGFILE_BYPASS_EN defined: write-to-read forwarding is enabled. If enable_write=1 and rd equals rs, rt, or the data_out address (rd itself, when output_enable=1) at the same edge, the corresponding output captures data_in, not the old contents. ZERO_R0 still forces 0 for register 0.
- CPU_REGFILE_BYPASS_EN undefined: outputs captured in the same edge as a write return the pre-write contents. The new value appears from the next read onward.
- Busy-bit clearing on a same-edge write (hazard_x) applies in both builds.

## Structure
- Shared package cpu_pkg holds:
  - DATA_W_DEF = 8 and ADDR_W_DEF = 4;
  - the typedefs data_t and reg_addr_t.
- One sub-module, cpu_scoreboard: NUM_REGS busy bits with set/clear priority and a registered hazard lookup for two addresses.
- Storage, read muxes, bypass and data_out stay in cpu_regfile_sb.

## Test plan
- Reset and write/read: assert rst=0 mid-run, then release; all outputs read 0. Write 30 to r4; set rs=4, rt=3 → reg_a=30 and reg_b=0 one cycle later.
- Bypass: enable_write=1, rd=5, data_in=0x5A, rs=5, all at the same edge → reg_a=0x5A with CPU_REGFILE_BYPASS_EN defined. Without the macro, reg_a holds the old value, and 0x5A appears the following cycle.
- Zero register (ZERO_R0=1): write 0xFF to r0 and issue r0 → reg_a=0 and hazard_a=0 for rs=0.
- Scoreboard: issue r7, then set rs=7 → hazard_a=1. Write r7 with 0x11 → hazard_a=0 and reg_a=0x11 on the next read.
- Issue/write collision: issue_valid=1, issue_rd=2, enable_write=1, rd=2, data_in=9, all at the same edge → reg[2]=9 and hazard_b=1 for rt=2.
- data_out: write 0x3C to r4; output_enable=1 with rd=4 → data_out=0x3C next cycle. Deassert output_enable → data_out=0. Assert rst=0 → data_out=0 immediately, without waiting for a clock edge.
